// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
// Contents:
//   REG_LEN       width of PC / branch target values
//   STG_*         stage index of each pipeline register in the stall/flush vectors
//   stage_vec_t   one bit per stage, index order PC, IF/ID, ID/EX, EX/MEM, MEM/WB
//   pc_state_t    controller states (RUN, REDIRECT)
//   *_MASK        stall/flush patterns applied for each arbitration outcome
package pipeline_ctrl_pkg;

   localparam int REG_LEN = 32;

   localparam int STG_PC    = 0;
   localparam int STG_IFID  = 1;
   localparam int STG_IDEX  = 2;
   localparam int STG_EXMEM = 3;
   localparam int STG_MEMWB = 4;
   localparam int STG_NUM   = 5;

   typedef logic [STG_NUM-1:0] stage_vec_t;

   // Two codes used; the spare encodings exist so a corrupted state
   // register has somewhere to recover from (it falls back to RUN).
   typedef enum logic [1:0] {
      PC_RUN      = 2'b00,
      PC_REDIRECT = 2'b01
   } pc_state_t;

   function automatic stage_vec_t stage_bit(input int idx);
      stage_vec_t v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Memory busy: freeze everything up to EX/MEM, bubble into MEM/WB.
   localparam stage_vec_t MEM_STALL_MASK = stage_bit(STG_PC) | stage_bit(STG_IFID) |
                                           stage_bit(STG_IDEX) | stage_bit(STG_EXMEM);
   localparam stage_vec_t MEM_FLUSH_MASK = stage_bit(STG_MEMWB);
   // Taken branch: kill the two younger instructions (in IF and ID).
   localparam stage_vec_t BR_FLUSH_MASK  = stage_bit(STG_IFID) | stage_bit(STG_IDEX);
   // Load-use: hold PC and IF/ID, insert a bubble into EX.
   localparam stage_vec_t ID_STALL_MASK  = stage_bit(STG_PC) | stage_bit(STG_IFID);
   localparam stage_vec_t ID_FLUSH_MASK  = stage_bit(STG_IDEX);
   // Fetch not ready: hold PC, bubble into ID.
   localparam stage_vec_t IF_STALL_MASK  = stage_bit(STG_PC);
   localparam stage_vec_t IF_FLUSH_MASK  = stage_bit(STG_IFID);
   // Redirect cycle: the instruction fetched on the wrong path is discarded.
   localparam stage_vec_t RD_FLUSH_MASK  = stage_bit(STG_IFID);

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the pipeline stages and the stall/flush sequencer.
//   master : pipeline side - drives the stall requests and branch result,
//            receives stall/flush vectors, redirect, error and perf counters
//   slave  : sequencer side - the mirror image
// Parameter CNT_W sets the width of the perf counter fields.
interface pipeline_ctrl_if #(
   parameter int CNT_W = 32
);
   import pipeline_ctrl_pkg::*;

   logic               if_stall_req;
   logic               id_stall_req;
   logic               mem_stall_req;
   logic               ex_branch_taken;
   logic [REG_LEN-1:0] ex_branch_target;
   stage_vec_t         stall;
   stage_vec_t         flush;
   logic               pc_redirect;
   logic [REG_LEN-1:0] pc_redirect_addr;
   logic               mem_timeout_err;
   logic [CNT_W-1:0]   perf_stall_cnt;
   logic [CNT_W-1:0]   perf_flush_cnt;

   modport master (
      output if_stall_req, id_stall_req, mem_stall_req,
      output ex_branch_taken, ex_branch_target,
      input  stall, flush, pc_redirect, pc_redirect_addr,
      input  mem_timeout_err, perf_stall_cnt, perf_flush_cnt
   );

   modport slave (
      input  if_stall_req, id_stall_req, mem_stall_req,
      input  ex_branch_taken, ex_branch_target,
      output stall, flush, pc_redirect, pc_redirect_addr,
      output mem_timeout_err, perf_stall_cnt, perf_flush_cnt
   );

endinterface

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Memory stall watchdog.
// Counts consecutive cycles of mem_stall_req; the count clears whenever the
// request drops. When the count reaches MEM_TIMEOUT the sticky timeout_err
// sets and stays set until rst. The count stops at MEM_TIMEOUT (no wrap).
// MEM_TIMEOUT = 0 disables the watchdog entirely.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mem_stall_req   data memory busy this cycle
//   timeout_err     sticky watchdog error
module pipeline_ctrl_stall_watchdog #(
   parameter int MEM_TIMEOUT = 1024,
   parameter int CNT_W       = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic mem_stall_req,
   output logic timeout_err
);

   generate
      if (MEM_TIMEOUT == 0) begin : g_off
         logic unused_inputs;
         assign unused_inputs = ^{clk, rst, mem_stall_req};
         assign timeout_err   = 1'b0;
      end else begin : g_on
         localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

         logic [CNT_W-1:0] cnt_reg, cnt_next;
         logic             err_reg, err_next;

         always_comb begin
            cnt_next = cnt_reg;
            err_next = err_reg;
            if (!mem_stall_req) begin
               cnt_next = '0;
            end else if (cnt_reg != LIMIT) begin
               cnt_next = cnt_reg + 1'b1;
            end
            // Error sets on the edge that completes the MEM_TIMEOUT-th stalled cycle.
            if (mem_stall_req && (cnt_next == LIMIT)) begin
               err_next = 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_reg <= '0;
               err_reg <= 1'b0;
            end else begin
               cnt_reg <= cnt_next;
               err_reg <= err_next;
            end
         end

         assign timeout_err = err_reg;
      end
   endgenerate

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Arbitrates IF/ID/MEM stall requests against taken branches from EX and
// drives per-stage hold (stall) and bubble (flush) vectors plus the PC
// redirect. stall/flush are combinational from the state and the requests;
// the state and the latched branch target are registered.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   pipeline_ctrl_if.slave: requests and branch in; stall, flush,
//         pc_redirect, pc_redirect_addr, mem_timeout_err, perf counters out
// Parameters:
//   MEM_TIMEOUT  stalled cycles before mem_timeout_err sets (0 = off)
//   CNT_W        watchdog and perf counter width
// Build option: define PIPE_PERF_CNT_EN to build the perf counters;
// otherwise perf_stall_cnt/perf_flush_cnt read 0 and no counter flops exist.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 1024,
   parameter int CNT_W       = 32
) (
   input  logic            clk,
   input  logic            rst,
   pipeline_ctrl_if.slave  bus
);

   pc_state_t          state_reg, state_next;
   logic [REG_LEN-1:0] target_reg, target_next;
   stage_vec_t         stall_vec, flush_vec;
   logic               redirect;

   always_comb begin
      state_next  = state_reg;
      target_next = target_reg;
      stall_vec   = '0;
      flush_vec   = '0;
      redirect    = 1'b0;
      case (state_reg)
         PC_RUN: begin
            if (bus.mem_stall_req) begin
               // EX is frozen, so a coincident branch is re-presented later.
               stall_vec = MEM_STALL_MASK;
               flush_vec = MEM_FLUSH_MASK;
            end else if (bus.ex_branch_taken) begin
               flush_vec   = BR_FLUSH_MASK;
               target_next = bus.ex_branch_target;
               state_next  = PC_REDIRECT;
            end else if (bus.id_stall_req) begin
               stall_vec = ID_STALL_MASK;
               flush_vec = ID_FLUSH_MASK;
            end else if (bus.if_stall_req) begin
               stall_vec = IF_STALL_MASK;
               flush_vec = IF_FLUSH_MASK;
            end
         end
         PC_REDIRECT: begin
            // Redirect waits out a memory stall with the target held.
            if (bus.mem_stall_req) begin
               stall_vec = MEM_STALL_MASK;
               flush_vec = MEM_FLUSH_MASK;
            end else begin
               redirect   = 1'b1;
               flush_vec  = RD_FLUSH_MASK;
               state_next = PC_RUN;
            end
         end
         default: begin
            state_next = PC_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= PC_RUN;
         target_reg <= '0;
      end else begin
         state_reg  <= state_next;
         target_reg <= target_next;
      end
   end

   pipeline_ctrl_stall_watchdog #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_watchdog (
      .clk           (clk),
      .rst           (rst),
      .mem_stall_req (bus.mem_stall_req),
      .timeout_err   (bus.mem_timeout_err)
   );

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_reg;
   logic [CNT_W-1:0] flush_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         if (|stall_vec) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
         end
         if ((state_reg == PC_RUN) && (state_next == PC_REDIRECT)) begin
            flush_cnt_reg <= flush_cnt_reg + 1'b1;
         end
      end
   end

   assign bus.perf_stall_cnt = stall_cnt_reg;
   assign bus.perf_flush_cnt = flush_cnt_reg;
`else
   assign bus.perf_stall_cnt = '0;
   assign bus.perf_flush_cnt = '0;
`endif

   assign bus.stall            = stall_vec;
   assign bus.flush            = flush_vec;
   assign bus.pc_redirect      = redirect;
   assign bus.pc_redirect_addr = target_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of the stall/flush rules.
module tb_pipeline_ctrl;
   localparam int T_OUT = 4;
   localparam int CW    = 32;

   logic clk;
   logic rst;

   pipeline_ctrl_if #(.CNT_W(CW)) bus();

   pipeline_ctrl #(
      .MEM_TIMEOUT (T_OUT),
      .CNT_W       (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Behavioural model: a branch is "pending" between acceptance and the
   // redirect cycle; memory stalls delay everything.
   bit          m_pending;
   logic [31:0] m_target;
   int          m_memrun;
   bit          m_err;
   logic [31:0] m_scnt;
   logic [31:0] m_fcnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_pending = 0;
      m_target  = '0;
      m_memrun  = 0;
      m_err     = 0;
      m_scnt    = '0;
      m_fcnt    = '0;
   endtask

   // One clock cycle: drive inputs, check outputs against the model mid-cycle,
   // then advance the model across the rising edge.
   task automatic cycle(input bit r, input bit m, input bit b, input bit i,
                        input bit f, input logic [31:0] t);
      logic [4:0] e_stall, e_flush;
      bit         e_redir, accept;
      rst                  = r;
      bus.mem_stall_req    = m;
      bus.ex_branch_taken  = b;
      bus.id_stall_req     = i;
      bus.if_stall_req     = f;
      bus.ex_branch_target = t;
      @(negedge clk);
      e_stall = 5'b00000;
      e_flush = 5'b00000;
      e_redir = 0;
      accept  = 0;
      if (m) begin
         e_stall = 5'b01111;
         e_flush = 5'b10000;
      end else if (m_pending) begin
         e_redir = 1;
         e_flush = 5'b00010;
      end else if (b) begin
         e_flush = 5'b00110;
         accept  = 1;
      end else if (i) begin
         e_stall = 5'b00011;
         e_flush = 5'b00100;
      end else if (f) begin
         e_stall = 5'b00001;
         e_flush = 5'b00010;
      end
      $display("cyc %0d rst=%0b mem=%0b br=%0b id=%0b if=%0b tgt=%h | stall=%b flush=%b redir=%0b addr=%h err=%0b",
               cyc, r, m, b, i, f, t, bus.stall, bus.flush, bus.pc_redirect,
               bus.pc_redirect_addr, bus.mem_timeout_err);
      chk("stall", 64'(bus.stall), 64'(e_stall));
      chk("flush", 64'(bus.flush), 64'(e_flush));
      chk("pc_redirect", 64'(bus.pc_redirect), 64'(e_redir));
      chk("pc_redirect_addr", 64'(bus.pc_redirect_addr), 64'(m_target));
      chk("mem_timeout_err", 64'(bus.mem_timeout_err), 64'(m_err));
`ifdef PIPE_PERF_CNT_EN
      chk("perf_stall_cnt", 64'(bus.perf_stall_cnt), 64'(m_scnt));
      chk("perf_flush_cnt", 64'(bus.perf_flush_cnt), 64'(m_fcnt));
`else
      chk("perf_stall_cnt_off", 64'(bus.perf_stall_cnt), 64'd0);
      chk("perf_flush_cnt_off", 64'(bus.perf_flush_cnt), 64'd0);
`endif
      // Model update across the edge.
      if (r) begin
         model_reset();
      end else begin
         if (e_stall != 5'b00000) m_scnt = m_scnt + 1;
         if (accept) begin
            m_pending = 1;
            m_target  = t;
            m_fcnt    = m_fcnt + 1;
         end else if (e_redir) begin
            m_pending = 0;
         end
         if (m) begin
            if (m_memrun < T_OUT) m_memrun++;
            if (m_memrun == T_OUT) m_err = 1;
         end else begin
            m_memrun = 0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 32'h0);
   endtask

   task automatic do_reset();
      cycle(1, 0, 0, 0, 0, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit exceeded");
   end

   initial begin
      // Test 1: reset for 2 cycles (outputs undefined before reset, not checked).
      rst = 1'b1;
      bus.mem_stall_req    = 0;
      bus.ex_branch_taken  = 0;
      bus.id_stall_req     = 0;
      bus.if_stall_req     = 0;
      bus.ex_branch_target = '0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      idle(2);
      chk("reset_err", 64'(bus.mem_timeout_err), 64'd0);
      chk("reset_addr", 64'(bus.pc_redirect_addr), 64'd0);

      // Test 2: single load-use stall.
      cycle(0, 0, 0, 1, 0, 32'h0);
      idle(1);

      // Fetch stall alone and combined with lower-priority requests.
      cycle(0, 0, 0, 0, 1, 32'h0);
      cycle(0, 0, 0, 1, 1, 32'h0);
      idle(1);

      // Test 3: taken branch to 0x100.
      cycle(0, 0, 1, 0, 0, 32'h100);
      chk("t3_addr", 64'(bus.pc_redirect_addr), 64'h100);
      cycle(0, 0, 1, 1, 1, 32'hDEAD);   // ignored during REDIRECT
      chk("t3_addr_hold", 64'(bus.pc_redirect_addr), 64'h100);
      idle(1);

      // Test 4: branch under memory stall for 3 cycles, then branch alone.
      repeat (3) cycle(0, 1, 1, 0, 0, 32'h200);
      chk("t4_no_latch", 64'(bus.pc_redirect_addr), 64'h100);
      cycle(0, 0, 1, 0, 0, 32'h200);
      chk("t4_addr", 64'(bus.pc_redirect_addr), 64'h200);
      cycle(0, 0, 0, 0, 0, 32'h0);
      idle(1);

      // Memory stall arriving during REDIRECT: redirect deferred, target kept.
      cycle(0, 0, 1, 0, 0, 32'h340);
      cycle(0, 1, 0, 0, 0, 32'h0);
      cycle(0, 1, 0, 0, 0, 32'h0);
      cycle(0, 0, 0, 0, 0, 32'h0);
      idle(1);

      // Reset in the middle of REDIRECT drops the redirect.
      cycle(0, 0, 1, 0, 0, 32'h480);
      do_reset();
      idle(2);
      chk("rst_mid_redirect_addr", 64'(bus.pc_redirect_addr), 64'd0);

      // Test 5: watchdog with MEM_TIMEOUT=4, request held 5 cycles.
      do_reset();
      repeat (3) cycle(0, 1, 0, 0, 0, 32'h0);
      chk("t5_err_before", 64'(bus.mem_timeout_err), 64'd0);
      cycle(0, 1, 0, 0, 0, 32'h0);
      chk("t5_err_after4", 64'(bus.mem_timeout_err), 64'd1);
      cycle(0, 1, 0, 0, 0, 32'h0);
      idle(3);
      chk("t5_err_sticky", 64'(bus.mem_timeout_err), 64'd1);
      do_reset();
      chk("t5_err_cleared", 64'(bus.mem_timeout_err), 64'd0);

      // Interrupted stall run of 3 must not trip the watchdog.
      repeat (3) cycle(0, 1, 0, 0, 0, 32'h0);
      idle(1);
      repeat (3) cycle(0, 1, 0, 0, 0, 32'h0);
      idle(1);
      chk("wd_run_cleared", 64'(bus.mem_timeout_err), 64'd0);

      // Test 6: two branches plus three stall cycles.
      do_reset();
      cycle(0, 0, 1, 0, 0, 32'h600);
      cycle(0, 0, 0, 0, 0, 32'h0);
      cycle(0, 0, 0, 1, 0, 32'h0);
      cycle(0, 0, 0, 0, 1, 32'h0);
      cycle(0, 0, 1, 0, 0, 32'h700);
      cycle(0, 0, 0, 0, 0, 32'h0);
      cycle(0, 0, 0, 1, 0, 32'h0);
      idle(1);
`ifdef PIPE_PERF_CNT_EN
      chk("t6_flush_cnt", 64'(bus.perf_flush_cnt), 64'd2);
      chk("t6_stall_cnt", 64'(bus.perf_stall_cnt), 64'd3);
`else
      chk("t6_flush_cnt_off", 64'(bus.perf_flush_cnt), 64'd0);
      chk("t6_stall_cnt_off", 64'(bus.perf_stall_cnt), 64'd0);
`endif

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         cycle(($urandom_range(0, 99) < 2),
               ($urandom_range(0, 99) < 25),
               ($urandom_range(0, 99) < 25),
               ($urandom_range(0, 99) < 20),
               ($urandom_range(0, 99) < 20),
               32'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
